grid_io_cfg_bank: RTL and testbench

- Parametrised successor to the fixed 8-pad I/O configuration memory bank: one transaction engine programs NUM_IO pads, each holding CFG_W configuration bits.
- Adds a valid/ready handshake, readback, broadcast write, an address range check and a "all pads programmed" flag.
- Sits inside grid_io_* tiles between the configuration protocol and the logical_tile_io instances.
- Drives their per-pad configuration bits.

---
 rtl/grid_io_cfg_bank.sv | 132 +++++++++++++
 tb/tb_grid_io_cfg_bank.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_cfg_bank.sv
// grid_io_cfg_bank: valid/ready configuration engine for NUM_IO pads, each holding CFG_W bits.
// Defining GRID_IO_CFG_PARITY_EN adds a cfg_parity input and rejects writes whose parity mismatches.
module grid_io_cfg_bank #(
   parameter int               NUM_IO  = 8,
   parameter int               ADDR_W  = 3,
   parameter int               CFG_W   = 4,
   parameter logic [CFG_W-1:0] CFG_RST = '0
) (
   input  logic                    prog_clk,
   input  logic                    pReset,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic                    cfg_wr,
   input  logic                    cfg_bcast,
   input  logic [ADDR_W-1:0]       cfg_addr,
   input  logic [CFG_W-1:0]        cfg_data,
   output logic                    resp_valid,
   output logic [CFG_W-1:0]        resp_data,
   output logic                    resp_err,
   output logic [NUM_IO*CFG_W-1:0] io_cfg,
   output logic                    cfg_done
`ifdef GRID_IO_CFG_PARITY_EN
   ,
   input  logic                    cfg_parity
`endif
);

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, RESP} state_t;

   localparam logic [ADDR_W:0] NUM_IO_L = (ADDR_W+1)'(NUM_IO);

   state_t              state;
   logic                wr_p0;
   logic                bcast_p0;
   logic [ADDR_W-1:0]   addr_p0;
   logic [CFG_W-1:0]    data_p0;
   logic                par_err_p0;
   logic                par_err_in;
   logic [NUM_IO-1:0]   en_nxt;
   logic                err_nxt;
   logic [NUM_IO-1:0]   en_p1;
   logic                err_p1;
   logic [NUM_IO-1:0]   written;
   logic [CFG_W-1:0]    rd_slice;

`ifdef GRID_IO_CFG_PARITY_EN
   assign par_err_in = cfg_wr & ((^cfg_data) ^ cfg_parity);
`else
   assign par_err_in = 1'b0;
`endif

   // stage p0: request captured at the handshake (ready is high only in IDLE)
   always_ff @(posedge prog_clk) begin
      if (state == IDLE && cfg_valid) begin
         wr_p0      <= cfg_wr;
         bcast_p0   <= cfg_bcast;
         addr_p0    <= cfg_addr;
         data_p0    <= cfg_data;
         par_err_p0 <= par_err_in;
      end
   end

   always_comb begin
      en_nxt = '0;
      for (int i = 0; i < NUM_IO; i++)
         en_nxt[i] = bcast_p0 | (addr_p0 == ADDR_W'(i));
      err_nxt = (!bcast_p0 && ({1'b0, addr_p0} >= NUM_IO_L)) || (!wr_p0 && bcast_p0) || par_err_p0;
   end

   // Reads never carry bcast without err, so en_p1 is one-hot whenever this is used.
   always_comb begin
      rd_slice = '0;
      for (int i = 0; i < NUM_IO; i++)
         if (en_p1[i]) rd_slice = io_cfg[i*CFG_W +: CFG_W];
   end

   // stage p1: decoded enables and err flag; EXEC commits, RESP pulses
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state      <= IDLE;
         cfg_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
         io_cfg     <= {NUM_IO{CFG_RST}};
         written    <= '0;
         cfg_done   <= 1'b0;
         en_p1      <= '0;
         err_p1     <= 1'b0;
      end else begin
         cfg_done <= &written;
         case (state)
            IDLE: begin
               if (cfg_valid) begin
                  cfg_ready <= 1'b0;
                  state     <= DECODE;
               end
            end
            DECODE: begin
               en_p1  <= en_nxt;
               err_p1 <= err_nxt;
               state  <= EXEC;
            end
            EXEC: begin
               if (err_p1) begin
                  resp_data <= '0;
               end else if (wr_p0) begin
                  for (int i = 0; i < NUM_IO; i++) begin
                     if (en_p1[i]) begin
                        io_cfg[i*CFG_W +: CFG_W] <= data_p0;
                        written[i]               <= 1'b1;
                     end
                  end
                  resp_data <= data_p0;
               end else begin
                  resp_data <= rd_slice;
               end
               resp_err   <= err_p1;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               cfg_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_grid_io_cfg_bank.sv
// Scoreboard bench for grid_io_cfg_bank: an 8-pad and a 6-pad instance share one request stream.
`timescale 1ns/1ps
module tb_grid_io_cfg_bank;

   typedef struct {
      bit          err;
      logic [3:0]  data;
      logic [31:0] io;
      bit          done;
      time         t;
   } exp_t;

   logic        prog_clk = 1'b0;
   logic        pReset   = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_wr = 1'b0;
   logic        cfg_bcast = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [3:0]  cfg_data = '0;
   logic        cfg_parity = 1'b0;

   logic        ready8, rv8, rerr8, done8;
   logic [3:0]  rd8;
   logic [31:0] io8;
   logic        ready6, rv6, rerr6, done6;
   logic [3:0]  rd6;
   logic [23:0] io6;

   int n_chk  = 0;
   int n_fail = 0;

   exp_t q8[$];
   exp_t q6[$];
   exp_t cur8, cur6;
   bit   pend8 = 0, pend6 = 0;
   logic [3:0] m [2][8];
   logic [7:0] w [2];
   time  t_last = 0;

   always #5 prog_clk = ~prog_clk;

   grid_io_cfg_bank #(.NUM_IO(8), .ADDR_W(3), .CFG_W(4), .CFG_RST(4'h0)) dut8 (
      .prog_clk(prog_clk), .pReset(pReset), .cfg_valid(cfg_valid), .cfg_ready(ready8),
      .cfg_wr(cfg_wr), .cfg_bcast(cfg_bcast), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .resp_valid(rv8), .resp_data(rd8), .resp_err(rerr8), .io_cfg(io8), .cfg_done(done8)
`ifdef GRID_IO_CFG_PARITY_EN
      , .cfg_parity(cfg_parity)
`endif
   );

   grid_io_cfg_bank #(.NUM_IO(6), .ADDR_W(3), .CFG_W(4), .CFG_RST(4'h0)) dut6 (
      .prog_clk(prog_clk), .pReset(pReset), .cfg_valid(cfg_valid), .cfg_ready(ready6),
      .cfg_wr(cfg_wr), .cfg_bcast(cfg_bcast), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .resp_valid(rv6), .resp_data(rd6), .resp_err(rerr6), .io_cfg(io6), .cfg_done(done6)
`ifdef GRID_IO_CFG_PARITY_EN
      , .cfg_parity(cfg_parity)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) m[k][i] = 4'h0;
         w[k] = '0;
      end
   endtask

   task automatic push_exp(input bit wr, input bit bc, input logic [2:0] a,
                           input logic [3:0] d, input bit par, input time t);
      exp_t e;
      int   n;
      bit   perr;
`ifdef GRID_IO_CFG_PARITY_EN
      perr = wr && ((^d) ^ par);
`else
      perr = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
         n = (k == 0) ? 8 : 6;
         e.err  = (!bc && a >= n) || (!wr && bc) || perr;
         e.data = 4'h0;
         if (!e.err && wr) begin
            for (int i = 0; i < n; i++)
               if (bc || a == i) begin
                  m[k][i] = d;
                  w[k][i] = 1'b1;
               end
            e.data = d;
         end else if (!e.err) begin
            e.data = m[k][a];
         end
         e.io = '0;
         for (int i = 0; i < n; i++) e.io[i*4 +: 4] = m[k][i];
         e.done = (k == 0) ? (&w[k]) : (&w[k][5:0]);
         e.t    = t;
         if (k == 0) q8.push_back(e);
         else        q6.push_back(e);
      end
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send(input bit wr, input bit bc, input logic [2:0] a, input logic [3:0] d,
                       input bit hold, input bit bad_par, input bit expect_resp, input bit chk_gap);
      int n;
      cfg_wr     = wr;
      cfg_bcast  = bc;
      cfg_addr   = a;
      cfg_data   = d;
      cfg_parity = (^d) ^ bad_par;
      cfg_valid  = 1'b1;
      n = 0;
      while (!ready8 && n < 20) begin
         @(negedge prog_clk);
         n++;
      end
      if (!ready8) begin
         chk("ready_timeout", ready8, 1);
         cfg_valid = 1'b0;
         return;
      end
      @(posedge prog_clk);
      if (chk_gap) chk("b2b_gap", $time - t_last, 40);
      t_last = $time;
      if (expect_resp) push_exp(wr, bc, a, d, cfg_parity, $time);
      @(negedge prog_clk);
      if (!hold) cfg_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q8.size() != 0 || q6.size() != 0 || pend8 || pend6) && n < 40) begin
         @(negedge prog_clk);
         n++;
      end
      chk("idle_timeout", 64'(q8.size() + q6.size()), 0);
   endtask

   task automatic do_reset();
      @(negedge prog_clk);
      pReset = 1'b1;
      @(negedge prog_clk);
      chk("rst_ready", ready8, 1);
      chk("rst_rv", rv8, 0);
      chk("rst_rdata", rd8, 0);
      chk("rst_rerr", rerr8, 0);
      chk("rst_io8", io8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_done6", done6, 0);
      pReset = 1'b0;
      model_clear();
      @(negedge prog_clk);
   endtask

   always @(negedge prog_clk) begin
      if (pend8) begin
         chk("done8", done8, cur8.done);
         chk("hold_data8", rd8, cur8.data);
         chk("hold_err8", rerr8, cur8.err);
         chk("pulse8", rv8, 0);
         pend8 = 0;
      end else if (rv8) begin
         if (q8.size() == 0) chk("unexp_resp8", rv8, 0);
         else begin
            cur8 = q8.pop_front();
            chk("lat8", $time - cur8.t, 25);
            chk("err8", rerr8, cur8.err);
            chk("data8", rd8, cur8.data);
            chk("io8", io8, cur8.io);
            chk("busy8", ready8, 0);
            pend8 = 1;
         end
      end
   end

   always @(negedge prog_clk) begin
      if (pend6) begin
         chk("done6", done6, cur6.done);
         chk("pulse6", rv6, 0);
         pend6 = 0;
      end else if (rv6) begin
         if (q6.size() == 0) chk("unexp_resp6", rv6, 0);
         else begin
            cur6 = q6.pop_front();
            chk("err6", rerr6, cur6.err);
            chk("data6", rd6, cur6.data);
            chk("io6", 64'(io6), 64'(cur6.io[23:0]));
            chk("busy6", ready6, 0);
            pend6 = 1;
         end
      end
   end

   initial begin
      model_clear();
      repeat (2) @(negedge prog_clk);
      chk("init_ready", ready8, 1);
      chk("init_rv", rv8, 0);
      chk("init_io8", io8, 0);
      chk("init_done8", done8, 0);
      pReset = 1'b0;
      @(negedge prog_clk);

      // write to pad 2 aborted by reset during EXEC
      send(1, 0, 3'd2, 4'h5, 0, 0, 0, 0);
      @(posedge prog_clk);
      #2 pReset = 1'b1;
      #1;
      chk("abort_io8", io8, 0);
      chk("abort_ready", ready8, 1);
      chk("abort_rv", rv8, 0);
      repeat (2) @(negedge prog_clk);
      chk("abort_done8", done8, 0);
      pReset = 1'b0;
      repeat (4) @(negedge prog_clk);
      chk("abort_io8_after", io8, 0);

      send(1, 0, 3'd5, 4'hA, 0, 0, 1, 0);
      send(0, 0, 3'd5, 4'h0, 0, 0, 1, 0);
      send(0, 0, 3'd3, 4'h0, 0, 0, 1, 0);
      send(1, 0, 3'd7, 4'hF, 0, 0, 1, 0);
      send(0, 1, 3'd0, 4'h0, 0, 0, 1, 0);
      wait_idle();

      do_reset();
      for (int i = 0; i < 7; i++) send(1, 0, 3'(i), 4'(i + 1), 0, 0, 1, 0);
      send(1, 0, 3'd7, 4'h9, 0, 0, 1, 0);
      send(1, 0, 3'd7, 4'hC, 0, 0, 1, 0);
      send(0, 0, 3'd6, 4'h0, 0, 0, 1, 0);

      send(1, 0, 3'($urandom_range(0, 7)), 4'($urandom), 1, 0, 1, 0);
      for (int i = 0; i < 5; i++)
         send(i[0], 0, 3'($urandom_range(0, 7)), 4'($urandom), (i != 4), 0, 1, 1);
      wait_idle();

      do_reset();
      send(1, 1, 3'd0, 4'h3, 0, 0, 1, 0);
      send(1, 0, 3'd0, 4'h1, 0, 0, 1, 0);
      send(0, 0, 3'd4, 4'h0, 0, 0, 1, 0);

`ifdef GRID_IO_CFG_PARITY_EN
      send(1, 0, 3'd4, 4'h7, 0, 1, 1, 0);
      send(1, 0, 3'd4, 4'h7, 0, 0, 1, 0);
      send(0, 0, 3'd4, 4'h0, 0, 1, 1, 0);
`endif
      wait_idle();
      repeat (2) @(negedge prog_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "timeout");
   end

endmodule
